// File: rtl/handshake_fifo_buffer.sv
// Register-based elastic FIFO stage for valid/ready handshake channels.
// Define HANDSHAKE_FIFO_BYPASS_EN to enable the zero-latency empty path.
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  empty;
    logic                  push;
    logic                  store;
    logic                  drain;

    assign empty     = (count == '0);
    // Ready depends only on registered occupancy, never on outs_ready.
    assign ins_ready = !rst && (count != FULL);
    assign push      = ins_valid && ins_ready;
    assign drain     = outs_ready && !empty;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
    assign outs_valid = !empty || (ins_valid && !rst);
    assign outs       = empty ? ins : mem[head];
    // A token that passes straight through while empty is never stored.
    assign store      = push && !(empty && outs_ready);
`else
    assign outs_valid = !empty;
    assign outs       = empty ? '0 : mem[head];
    assign store      = push;
`endif

    always_ff @(posedge clk) begin
        if (store) begin
            mem[tail] <= ins;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store) begin
                tail <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (drain) begin
                head <= (head == LAST) ? '0 : head + 1'b1;
            end
            case ({store, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Scoreboard bench for handshake_fifo_buffer: directed and random traffic
// checked against a queue-based reference model of the FIFO.
module tb_handshake_fifo_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic [DW-1:0] outs;
    logic          outs_valid;
    logic          outs_ready;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q [$];
    logic          toggle = 1'b0;

    handshake_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [DW-1:0] actual,
                                input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Inputs change 2 time units after the rising edge and stay put until the next one.
    task automatic apply_stimulus(input logic v, input logic [DW-1:0] d,
                                  input logic ordy, input logic r);
        @(posedge clk);
        #2;
        ins_valid  = v;
        ins        = d;
        outs_ready = ordy;
        rst        = r;
    endtask

    function automatic logic ready_for(input int rmode);
        if (rmode == 2) begin
            toggle = ~toggle;
            return toggle;
        end
        return (rmode == 1);
    endfunction

    // Offer one token, holding it stable until the FIFO accepts it.
    task automatic push_token(input logic [DW-1:0] d, input int rmode);
        logic accepted = 1'b0;
        for (int tries = 0; tries < 100 && !accepted; tries++) begin
            apply_stimulus(1'b1, d, ready_for(rmode), 1'b0);
            @(negedge clk);
            accepted = ins_ready;
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("[TB] FAIL push_timeout: token %h never accepted, expected acceptance within 100 cycles", d);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, '0, ordy, 1'b0);
        end
    endtask

    // Reference model: occupancy and ordering come from the queue alone; every
    // transfer decision is taken mid-cycle for the rising edge that follows.
    always @(negedge clk) begin
        int            sz;
        logic          byp;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        sz = exp_q.size();
`ifdef HANDSHAKE_FIFO_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        exp_valid = (sz != 0) || (byp && ins_valid && !rst);
        if (sz != 0)  exp_data = exp_q[0];
        else if (byp) exp_data = ins;
        else          exp_data = '0;

        check_output("outs_valid", DW'(outs_valid), DW'(exp_valid));
        check_output("ins_ready", DW'(ins_ready), DW'(!rst && sz < DEPTH));
        check_output("outs", outs, exp_data);

        if (sz != 0 && outs_ready) begin
            void'(exp_q.pop_front());
        end
        if (rst) begin
            exp_q.delete();
        end else if (ins_valid && sz < DEPTH && !(byp && sz == 0 && outs_ready)) begin
            exp_q.push_back(ins);
        end
    end

    initial begin
        logic          pending;
        logic [DW-1:0] pdata;
        rst        = 1'b1;
        ins        = '0;
        ins_valid  = 1'b0;
        outs_ready = 1'b0;

        $display("[TB] reset then idle");
        apply_stimulus(1'b0, '0, 1'b1, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1);
        idle(3, 1'b1);

        $display("[TB] single token");
        push_token(32'h0000_D562, 1);
        idle(3, 1'b1);

        $display("[TB] fill, backpressure and full-with-pop");
        for (int i = 1; i <= 4; i++) push_token(DW'(i), 0);
        idle(2, 1'b0);
        push_token(32'h5, 1);
        idle(8, 1'b1);

        $display("[TB] wrap-around streaming");
        for (int i = 0; i < 20; i++) push_token(DW'(i), 2);
        idle(10, 1'b1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) push_token(32'hA0 + DW'(i), 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        idle(2, 1'b0);
        push_token(32'h0000_ABCD, 0);
        idle(3, 1'b1);

        $display("[TB] random traffic");
        pending = 1'b0;
        pdata   = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pending) begin
                pending = ($urandom_range(0, 2) != 0);
                pdata   = $urandom;
            end
            apply_stimulus(pending, pending ? pdata : '0,
                           ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
            @(negedge clk);
            if (pending && ins_ready) pending = 1'b0;
        end
        idle(10, 1'b1);
        @(negedge clk);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/handshake_fifo_buffer.md
Name: handshake_fifo_buffer

Overview:
- Elastic FIFO buffer stage for the handshake dataflow fabric, DEPTH entries, register-based.
- Sits directly downstream of handshake constant, operator and fork units.
- Consumes their outs/outs_valid/outs_ready channel and re-presents it to the next unit.
- Breaks the valid/data path and the ready path so long handshake chains close timing.

Parameters:
DATA_WIDTH, 32, width of the data payload
DEPTH, 4, number of storage entries; legal values are integers >= 2 (power of two not required)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
ins  input  DATA_WIDTH  input channel data
ins_valid  input  1  input channel valid
ins_ready  output  1  input channel ready
outs  output  DATA_WIDTH  output channel data
outs_valid  output  1  output channel valid
outs_ready  input  1  output channel ready

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- State:
  - storage array mem[0..DEPTH-1], not reset;
  - head (read) and tail (write) pointers, width clog2(DEPTH);
  - count, width clog2(DEPTH+1).
- Reset: while rst=1, head=tail=count=0 at the clock edge. Outputs during and after reset until the first push: outs_valid=0, ins_ready=0 while rst=1, ins_ready=1 once rst=0, outs=0.
- Transfers:
  - push = ins_valid & ins_ready;
  - pop = outs_valid & outs_ready.
- Ready and valid rules:
  - ins_ready = !rst & (count != DEPTH). It is a function of registered state only, with no combinational path from outs_ready. When full, no push occurs even if a pop happens in the same cycle.
  - outs_valid = (count != 0). outs = mem[head] when count != 0, else all zeros.
- Latency: data pushed in cycle N appears on outs in cycle N+1 at the earliest (when the FIFO was empty).
- Push: mem[tail] <= ins; tail increments, wrapping from DEPTH-1 to 0 by explicit compare.
- Pop: head increments with the same wrap rule.
- Count update:
  - push only: +1;
  - pop only: -1;
  - push and pop together: unchanged, both pointers advance;
  - neither: unchanged.
- Ordering: strict FIFO, no reorder, no drop, no duplication. A held outs value stays stable while outs_valid=1 and outs_ready=0.
- Boundaries:
  - Full (count=DEPTH): ins_ready=0. A pop that cycle gives count=DEPTH-1 and ins_ready=1 next cycle.
  - Empty (count=0): outs_valid=0 and outs_ready is ignored.
- Reset mid-operation: all buffered tokens are discarded. outs_valid=0 in the cycle after the reset edge.
- Upstream protocol: upstream must hold ins stable while ins_valid=1 and ins_ready=0. The block does not check this.

Optional Feature:
- Macro: HANDSHAKE_FIFO_BYPASS_EN.
- Defined (zero-latency empty path):
  - outs_valid = ins_valid | (count != 0);
  - outs = (count == 0) ? ins : mem[head].
  - ins_ready is unchanged.
  - Empty, ins_valid=1, outs_ready=1: the token passes through in the same cycle and is not stored; count stays 0.
  - Empty, ins_valid=1, outs_ready=0: the token is stored as normal.
- Undefined: behaviour exactly as specified above, with 1-cycle minimum latency.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 -> outs_valid=0, outs=0, ins_ready=0 during reset and ins_ready=1 after.
- Single token, DEPTH=4, outs_ready=1: ins=0x0000D562 valid for 1 cycle -> outs=0x0000D562, outs_valid=1 exactly one cycle later (same cycle with BYPASS_EN), then outs_valid=0.
- Fill and backpressure, outs_ready=0: push 0x1, 0x2, 0x3, 0x4 -> ins_ready=0 after the 4th push, outs holds 0x1. Then outs_ready=1 -> outputs 0x1, 0x2, 0x3, 0x4 in order, and ins_ready returns to 1 the cycle after the first pop.
- Full with simultaneous pop: count=4, ins_valid=1, outs_ready=1 -> no push that cycle, count=3. The next cycle pushes, with count staying 3.
- Wrap-around and streaming: 20 consecutive tokens 0..19 with outs_ready toggling 1,0,1,0 -> outputs exactly 0..19 in order, with no loss or duplicates across several pointer wraps.
- Reset mid-operation: 3 tokens buffered, pulse rst=1 for 1 cycle -> outs_valid=0 the next cycle, and the first token pushed afterwards is the first one output.
